serial_frame_seq: RTL and testbench



---
 rtl/serial_frame_pkg.sv | 19 +
 rtl/frame_shreg.sv | 48 ++++
 rtl/serial_frame_seq.sv | 143 ++++++++++++++
 tb/tb_serial_frame_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types, reset values and the frame-length clamp for serial_frame_seq.
package serial_frame_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e STATE_RST = ST_IDLE;
  localparam logic   BIT_RST   = 1'b0;

  // Map a requested frame length onto the legal range 1..dw.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned dw);
    if (len == 0)  return 1;
    if (len > dw)  return dw;
    return len;
  endfunction

endpackage

// File: rtl/frame_shreg.sv
// DW-bit serial shift register with a running XOR parity of the bits shifted in.
module frame_shreg
  import serial_frame_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          shift_en_i,
  input  logic          d_i,
  output logic [DW-1:0] shreg_o,
  output logic          par_o
);

  logic [DW-1:0] shreg_q, shreg_d;
  logic          par_q, par_d;

  // Next value: clear wins over shift, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shreg_d = shreg_q;
    par_d   = par_q;
    if (clr_i) begin
      shreg_d = '0;
      par_d   = BIT_RST;
    end else if (shift_en_i) begin
      shreg_d = {shreg_q[DW-2:0], d_i};
      par_d   = par_q ^ d_i;
    end
  end

  // Shift/parity registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_ni) begin
      shreg_q <= '0;
      par_q   <= BIT_RST;
    end else begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

  assign shreg_o = shreg_q;
  assign par_o   = par_q;

endmodule

// File: rtl/serial_frame_seq.sv
// Frames a serial bit stream into programmable-length words, strobes each frame end,
// and presents word+parity through a VALID/READY register with sticky overflow.
module serial_frame_seq
  import serial_frame_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 4,
  parameter int FW = 8
) (
  input  logic          C,
  input  logic          NR,
  input  logic          EN,
  input  logic [LW-1:0] LEN,
  input  logic          D,
  input  logic          READY,
  input  logic          CLR_OVF,
  output logic [DW-1:0] WORD,
  output logic          PAR,
  output logic          VALID,
  output logic          STROBE,
  output logic          OVF,
  output logic          BUSY,
  output logic [FW-1:0] FCNT
);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] word_q, word_d;
  logic          par_q, par_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;
  logic          ovf_q, ovf_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  logic [DW-1:0] shreg;
  logic          shpar;
  logic          sh_clr, sh_en;
  logic          frame_end;
  logic [LW-1:0] len_clamped;
  logic          unused_shreg_msb;

  // The oldest shift bit falls off when the final bit is appended.
  assign unused_shreg_msb = shreg[DW-1];

  assign len_clamped = LW'(clamp_len(32'(LEN), DW));
  assign frame_end   = (state_q == ST_RUN) && (cnt_q == len_q - LW'(1));

  frame_shreg #(.DW(DW)) u_shreg (
    .clk_i      (C),
    .rst_ni     (NR),
    .clr_i      (sh_clr),
    .shift_en_i (sh_en),
    .d_i        (D),
    .shreg_o    (shreg),
    .par_o      (shpar)
  );

  // FSM next state, bit counter, output register, handshake and overflow.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    par_d    = par_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    fcnt_d   = fcnt_q;
    strobe_d = 1'b0;
    sh_clr   = 1'b0;
    sh_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (EN) begin
          state_d = ST_RUN;
          len_d   = len_clamped;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          // Capture the completed frame including the bit on D this edge.
          word_d   = {shreg[DW-2:0], D};
          par_d    = shpar ^ D;
          fcnt_d   = fcnt_q + FW'(1);
          strobe_d = 1'b1;
          cnt_d    = '0;
          sh_clr   = 1'b1;
          if (EN) len_d = len_clamped;
          else    state_d = ST_IDLE;
        end else begin
          sh_en = 1'b1;
          cnt_d = cnt_q + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing frame always leaves VALID set; otherwise a transfer clears it.
    if (frame_end)             valid_d = 1'b1;
    else if (valid_q && READY) valid_d = 1'b0;

    // Overwrite of an unconsumed frame beats a simultaneous clear.
    if (frame_end && valid_q && !READY) ovf_d = 1'b1;
    else if (CLR_OVF)                   ovf_d = 1'b0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge C) begin
    if (!NR) begin
      state_q  <= STATE_RST;
      len_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      par_q    <= BIT_RST;
      valid_q  <= BIT_RST;
      strobe_q <= BIT_RST;
      ovf_q    <= BIT_RST;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      par_q    <= par_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign WORD   = word_q;
  assign PAR    = par_q;
  assign VALID  = valid_q;
  assign STROBE = strobe_q;
  assign OVF    = ovf_q;
  assign BUSY   = (state_q == ST_RUN);
  assign FCNT   = fcnt_q;

endmodule

// File: tb/tb_serial_frame_seq.sv
// Self-checking bench for serial_frame_seq: directed scenarios plus randomized
// traffic against a bit-queue reference model.
module tb_serial_frame_seq;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int FW = 8;

  logic          C = 1'b0;
  logic          NR = 1'b0;
  logic          EN = 1'b0;
  logic [LW-1:0] LEN = '0;
  logic          D = 1'b0;
  logic          READY = 1'b0;
  logic          CLR_OVF = 1'b0;
  logic [DW-1:0] WORD;
  logic          PAR, VALID, STROBE, OVF, BUSY;
  logic [FW-1:0] FCNT;

  serial_frame_seq #(.DW(DW), .LW(LW), .FW(FW)) dut (
    .C(C), .NR(NR), .EN(EN), .LEN(LEN), .D(D), .READY(READY), .CLR_OVF(CLR_OVF),
    .WORD(WORD), .PAR(PAR), .VALID(VALID), .STROBE(STROBE), .OVF(OVF),
    .BUSY(BUSY), .FCNT(FCNT)
  );

  always #5 C = ~C;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of sampled bits; the word is its
  // binary value (first bit most significant), parity is the count of ones mod 2.
  bit m_run;
  int m_len;
  bit m_bits[$];
  int m_word;
  bit m_par, m_valid, m_strobe, m_ovf;
  int m_fcnt;

  function automatic int ref_clamp(input int l);
    if (l == 0)  return 1;
    if (l > DW)  return DW;
    return l;
  endfunction

  task automatic model_edge();
    bit done;
    bit old_valid;
    done      = 1'b0;
    old_valid = m_valid;
    if (!NR) begin
      m_run = 0; m_len = 0; m_bits.delete(); m_word = 0; m_par = 0;
      m_valid = 0; m_strobe = 0; m_ovf = 0; m_fcnt = 0;
      return;
    end
    m_strobe = 0;
    if (!m_run) begin
      if (EN) begin
        m_run = 1;
        m_len = ref_clamp(int'(LEN));
        m_bits.delete();
      end
    end else begin
      m_bits.push_back(D);
      if (m_bits.size() == m_len) begin
        done   = 1'b1;
        m_word = 0;
        m_par  = 0;
        foreach (m_bits[i]) begin
          m_word = (m_word << 1) | int'(m_bits[i]);
          m_par  = m_par ^ m_bits[i];
        end
        m_fcnt   = (m_fcnt + 1) % (1 << FW);
        m_strobe = 1;
        m_bits.delete();
        if (EN) m_len = ref_clamp(int'(LEN));
        else    m_run = 0;
      end
    end
    if (done && old_valid && !READY) m_ovf = 1;
    else if (CLR_OVF)                m_ovf = 0;
    if (done)                        m_valid = 1;
    else if (old_valid && READY)     m_valid = 0;
  endtask

  task automatic compare_all();
    check("word",   32'(WORD),   32'(m_word));
    check("par",    32'(PAR),    32'(m_par));
    check("valid",  32'(VALID),  32'(m_valid));
    check("strobe", 32'(STROBE), 32'(m_strobe));
    check("ovf",    32'(OVF),    32'(m_ovf));
    check("busy",   32'(BUSY),   32'(m_run));
    check("fcnt",   32'(FCNT),   32'(m_fcnt));
  endtask

  // One clock: advance model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge C);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    NR = 1'b0;
    step();
    NR = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;

    // Reset held for three edges with EN high and D toggling.
    NR = 1'b0; EN = 1'b1; LEN = 4'd3;
    for (int i = 0; i < 3; i++) begin
      D = ~D;
      step();
    end
    check("rst_word",  32'(WORD),  32'h0);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_busy",  32'(BUSY),  32'h0);
    check("rst_fcnt",  32'(FCNT),  32'h0);

    // Basic LEN=3 frame: bits 1,0,1.
    NR = 1'b1; READY = 1'b1; EN = 1'b1; LEN = 4'd3;
    step();
    check("start_busy", 32'(BUSY), 32'h1);
    D = 1; step(); D = 0; step(); D = 1; step();
    check("basic_word",   32'(WORD),   32'h05);
    check("basic_par",    32'(PAR),    32'h0);
    check("basic_valid",  32'(VALID),  32'h1);
    check("basic_strobe", 32'(STROBE), 32'h1);
    check("basic_fcnt",   32'(FCNT),   32'h1);

    // Back-to-back frames with no gap.
    D = 1; step();
    check("b2b_strobe_low", 32'(STROBE), 32'h0);
    check("b2b_consumed",   32'(VALID),  32'h0);
    D = 1; step(); D = 1; step();
    check("b2b1_word",   32'(WORD),   32'h07);
    check("b2b1_par",    32'(PAR),    32'h1);
    check("b2b1_strobe", 32'(STROBE), 32'h1);
    D = 0; step(); D = 1; step(); D = 1; step();
    check("b2b2_word",   32'(WORD),   32'h03);
    check("b2b2_par",    32'(PAR),    32'h0);
    check("b2b2_strobe", 32'(STROBE), 32'h1);
    check("b2b2_fcnt",   32'(FCNT),   32'h3);

    // Overflow: two LEN=2 frames with READY low, then clear.
    do_reset();
    READY = 1'b0; EN = 1'b1; LEN = 4'd2;
    step();
    D = 1; step(); D = 0; step();
    check("ovf_first_word", 32'(WORD), 32'h02);
    check("ovf_first_ovf",  32'(OVF),  32'h0);
    D = 1; step();
    EN = 1'b0; D = 1; step();
    check("ovf_word",  32'(WORD),  32'h03);
    check("ovf_par",   32'(PAR),   32'h0);
    check("ovf_flag",  32'(OVF),   32'h1);
    check("ovf_valid", 32'(VALID), 32'h1);
    check("ovf_idle",  32'(BUSY),  32'h0);
    CLR_OVF = 1'b1; READY = 1'b1;
    step();
    check("clr_ovf",   32'(OVF),   32'h0);
    check("clr_valid", 32'(VALID), 32'h0);
    CLR_OVF = 1'b0;

    // LEN=0 clamps to 1: strobe stays high.
    do_reset();
    EN = 1'b1; LEN = 4'd0;
    step();
    for (int i = 0; i < 6; i++) begin
      D = 1'($urandom);
      step();
      check("len1_strobe", 32'(STROBE), 32'h1);
      check("len1_word",   32'(WORD),   32'(D));
    end

    // LEN=12 clamps to DW=8.
    do_reset();
    EN = 1'b1; LEN = 4'd12;
    step();
    pat = 8'hA7;
    for (int i = 7; i >= 0; i--) begin
      D = pat[i];
      step();
      if (i > 0) check("len12_strobe_low", 32'(STROBE), 32'h0);
    end
    check("len12_word",   32'(WORD),   32'hA7);
    check("len12_par",    32'(PAR),    32'h1);
    check("len12_strobe", 32'(STROBE), 32'h1);

    // EN dropped (and LEN changed) mid-frame: frame still completes at 8 bits.
    do_reset();
    EN = 1'b1; LEN = 4'd8;
    step();
    D = 1; step(); D = 1; step();
    EN = 1'b0; LEN = 4'd2; D = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stop_still_busy", 32'(BUSY), 32'h1);
    end
    step();
    check("stop_word",  32'(WORD),   32'hC0);
    check("stop_valid", 32'(VALID),  32'h1);
    check("stop_busy",  32'(BUSY),   32'h0);
    step();
    check("stop_stays_idle", 32'(BUSY), 32'h0);

    // Reset mid-frame discards the partial frame.
    do_reset();
    EN = 1'b1; LEN = 4'd5;
    step();
    D = 1; step(); D = 1; step();
    NR = 1'b0; step();
    check("midrst_valid", 32'(VALID), 32'h0);
    check("midrst_busy",  32'(BUSY),  32'h0);
    NR = 1'b1; EN = 1'b0;
    repeat (3) step();
    check("midrst_idle",  32'(BUSY),  32'h0);
    check("midrst_novalid", 32'(VALID), 32'h0);
    EN = 1'b1;
    step();
    check("midrst_restart", 32'(BUSY), 32'h1);

    // FCNT wraps after 256 one-bit frames.
    do_reset();
    EN = 1'b1; LEN = 4'd1; READY = 1'b1;
    step();
    for (int i = 0; i < 256; i++) begin
      D = 1'($urandom);
      step();
    end
    check("fcnt_wrap", 32'(FCNT), 32'h0);

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      NR      = ($urandom_range(0, 199) != 0);
      EN      = ($urandom_range(0, 9) != 0);
      LEN     = LW'($urandom_range(0, 15));
      D       = 1'($urandom);
      READY   = 1'($urandom);
      CLR_OVF = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
